gpio_bank: RTL and testbench
============================

Name: gpio_bank

Overview:
- Parametrised memory-mapped GPIO bank; successor to the fixed two-port peripheral pair in the memory-peripheral layer.
- Gives N_CH independent bidirectional channels, each with its own direction bit, plus a 2-flop input synchroniser, rising/falling edge capture and a single level interrupt.
- Sits on the CPU data bus behind the peripheral chip-select; supports the existing byte/half/word/double STUR/LDUR size encoding.
- Pad tristate is resolved outside the block: the block drives pin_out and pin_oe and samples pin_in.

Parameters:
- N_CH, 13, number of GPIO channels (1..64).
- DATA_W, 64, bus data width.
- ADDR_W, 3, register index width (word-indexed register offset).
- SYNC_STAGES, 2, input synchroniser depth (≥2).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cs  in  1  peripheral chip select.
- rd  in  1  read strobe; qualified by cs.
- wr  in  1  write strobe; qualified by cs.
- addr  in  ADDR_W  register index.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse; rdata is valid while it is high.
- pin_in  in  N_CH  raw pad inputs, asynchronous.
- pin_out  out  N_CH  output data register.
- pin_oe  out  N_CH  per-channel output enable (1 = drive).
- irq  out  1  registered interrupt request.

Behaviour:
- Reset (async, reset=0) clears OUT, DIR, RISE_EN, FALL_EN, EDGE_STAT, IRQ_EN, the synchroniser chain, the prev register, rdata, rd_valid and irq.
  - Outputs after reset: pin_out=0, pin_oe=0 (all channels inputs), irq=0, rd_valid=0, rdata=0.
  - Reset may assert mid-access; any pending read is dropped.
- Register map (addr): 0 OUT RW; 1 DIR RW (1=output); 2 IN RO (synchronised pins); 3 RISE_EN RW; 4 FALL_EN RW; 5 EDGE_STAT R/W1C; 6 IRQ_EN RW (bit0 only); 7 reads 0, writes ignored.
- Read-back: unimplemented bits above N_CH read 0.
- Write (cs&wr): takes effect at the clock edge.
  - Byte lane mask from size: 00→bits[7:0], 01→[15:0], 10→[31:0], 11→all.
  - Bits outside the mask keep their old value. For EDGE_STAT, bits outside the mask are not cleared.
  - Writes to IN or addr 7 have no effect.
- Read (cs&rd&~wr): rdata is loaded with the full register value at the edge; rd_valid pulses high for the following cycle only.
  - Size does not mask reads; the CPU truncates.
  - rdata holds its value until the next read.
  - Back-to-back reads give one rd_valid per request.
- cs&rd&wr in the same cycle: the write is performed, the read is ignored, and there is no rd_valid.
- Strobes with cs=0 are ignored.
- pin_out = OUT[N_CH-1:0]; pin_oe = DIR[N_CH-1:0]. Both are combinational from the registers, so they change in the cycle after the write edge.
- Input path: pin_in passes through SYNC_STAGES flops to give sync. prev is sync delayed by one cycle.
  - rise = sync & ~prev & RISE_EN; fall = ~sync & prev & FALL_EN.
  - A pin change reaches sync after SYNC_STAGES edges and sets EDGE_STAT one edge later.
  - Edge detection runs regardless of DIR, so output channels can self-detect.
- EDGE_STAT bit update: next = (stat & ~w1c_mask) | rise | fall. If a set and a W1C on the same bit land in the same cycle, the set wins.
- irq is registered: irq <= IRQ_EN[0] & |EDGE_STAT. It rises one cycle after the first stat bit sets and falls one cycle after the last bit clears or IRQ_EN is cleared.
- IN read returns sync, not raw pin_in.

Decomposition:
- Package gpio_pkg holds:
  - register offsets: GPIO_OUT=0, GPIO_DIR=1, GPIO_IN=2, GPIO_RISE_EN=3, GPIO_FALL_EN=4, GPIO_STAT=5, GPIO_IRQ_EN=6;
  - size encodings: SZ_B, SZ_H, SZ_W, SZ_D;
  - the lane-mask function.
- Sub-module gpio_sync_edge (parameters N_CH, SYNC_STAGES): synchroniser chain, prev register, rise/fall vectors. gpio_bank holds the register file, bus logic and irq.

Test Plan:
- Reset then read DIR, OUT and STAT → rdata=0, rd_valid=1 for exactly one cycle; pin_oe=0, irq=0.
- size=11, write OUT=0x1ABC, DIR=0x1FFF → pin_out=0x1ABC, pin_oe=0x1FFF next cycle. Then size=00 write OUT=0xFF → OUT=0x1AFF; read back 0x1AFF (bit 13+ = 0).
- RISE_EN=0x0004, IRQ_EN=1; pin_in[2] 0→1 → STAT bit2 set at edge 3 after the change, irq=1 the cycle after; a falling edge on pin 2 does not set STAT.
- FALL_EN=0x0001, toggle pin0 1→0; write STAT=0x1 on the exact cycle the fall is detected → bit0 stays 1. A second W1C 0x1 clears it → irq drops the next cycle.
- cs&rd&wr together with addr=0, wdata=0x5 → OUT=0x5, rd_valid stays 0. Write with cs=0 → no change. Read addr 7 → rdata=0.
- Assert reset mid-read (rd issued, reset falls before the next edge) → rd_valid never pulses; all registers are 0 after release.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO bank.
//   - Register offsets (word-indexed) of the bank's register map.
//   - Access-size encodings used by the CPU load/store path.
//   - lane_mask(): byte-lane write mask for a given access size.
package gpio_pkg;

    localparam int GPIO_OUT     = 0;
    localparam int GPIO_DIR     = 1;
    localparam int GPIO_IN      = 2;
    localparam int GPIO_RISE_EN = 3;
    localparam int GPIO_FALL_EN = 4;
    localparam int GPIO_STAT    = 5;
    localparam int GPIO_IRQ_EN  = 6;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    // Bits a write of the given size is allowed to touch (64-bit bus max).
    function automatic logic [63:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 64'h0000_0000_0000_00FF;
            SZ_H:    return 64'h0000_0000_0000_FFFF;
            SZ_W:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// gpio_bank_if: CPU-side peripheral bus of the GPIO bank.
//   cs/rd/wr  chip select and strobes (master -> slave)
//   addr      word register index
//   size      access size (byte/half/word/double)
//   wdata     write data
//   rdata     registered read data (slave -> master)
//   rd_valid  one-cycle pulse, rdata valid while high
interface gpio_bank_if
    import gpio_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 3
) ();
    logic              cs;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rd_valid;

    modport master (
        output cs, rd, wr, addr, size, wdata,
        input  rdata, rd_valid
    );

    modport slave (
        input  cs, rd, wr, addr, size, wdata,
        output rdata, rd_valid
    );
endinterface

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: input synchroniser and edge detector for the GPIO bank.
//   clock, reset      system clock, async active-low reset
//   pin_in            raw asynchronous pad inputs
//   rise_en, fall_en  per-channel edge enables
//   sync              pin_in after SYNC_STAGES flops
//   rise, fall        enabled edge strobes (combinational from sync/prev)
module gpio_sync_edge
    import gpio_pkg::*;
#(
    parameter int N_CH        = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_CH-1:0] pin_in,
    input  logic [N_CH-1:0] rise_en,
    input  logic [N_CH-1:0] fall_en,
    output logic [N_CH-1:0] sync,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);
    logic [N_CH-1:0] prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            logic [N_CH-1:0] q_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clock or negedge reset) begin
                    if (!reset) q_reg <= '0;
                    else        q_reg <= pin_in;
                end
            end else begin : g_next
                always_ff @(posedge clock or negedge reset) begin
                    if (!reset) q_reg <= '0;
                    else        q_reg <= g_stage[gi-1].q_reg;
                end
            end
        end
    endgenerate

    assign sync = g_stage[SYNC_STAGES-1].q_reg;

    // prev lags sync by one cycle so a level change shows up as a one-cycle strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) prev_reg <= '0;
        else        prev_reg <= sync;
    end

    assign rise = sync & ~prev_reg & rise_en;
    assign fall = ~sync & prev_reg & fall_en;

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped bank of N_CH bidirectional GPIO channels.
//   clock, reset  system clock, async active-low reset
//   bus           CPU peripheral bus (gpio_bank_if slave)
//   pin_in        raw pad inputs
//   pin_out       output data register
//   pin_oe        per-channel output enable (1 = drive)
//   irq           registered level interrupt: IRQ_EN[0] & |EDGE_STAT
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int N_CH        = 13,
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clock,
    input  logic            reset,
    gpio_bank_if.slave      bus,
    input  logic [N_CH-1:0] pin_in,
    output logic [N_CH-1:0] pin_out,
    output logic [N_CH-1:0] pin_oe,
    output logic            irq
);
    logic [N_CH-1:0]   out_reg, dir_reg, rise_en_reg, fall_en_reg, stat_reg;
    logic [N_CH-1:0]   out_next, dir_next, rise_en_next, fall_en_next, stat_next;
    logic              irq_en_reg, irq_en_next;
    logic              irq_reg;
    logic [DATA_W-1:0] rdata_reg, rd_mux;
    logic              rd_valid_reg;

    logic [N_CH-1:0]   sync, rise, fall;
    logic [N_CH-1:0]   wr_mask, wr_bits, w1c;
    logic [63:0]       lane;
    logic              write_en, read_en;

    gpio_sync_edge #(
        .N_CH        (N_CH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clock   (clock),
        .reset   (reset),
        .pin_in  (pin_in),
        .rise_en (rise_en_reg),
        .fall_en (fall_en_reg),
        .sync    (sync),
        .rise    (rise),
        .fall    (fall)
    );

    // A simultaneous write wins over a read: no read data, no rd_valid.
    assign write_en = bus.cs & bus.wr;
    assign read_en  = bus.cs & bus.rd & ~bus.wr;

    assign lane    = lane_mask(bus.size);
    assign wr_mask = N_CH'(lane);
    assign wr_bits = N_CH'(bus.wdata) & wr_mask;

    always_comb begin
        out_next     = out_reg;
        dir_next     = dir_reg;
        rise_en_next = rise_en_reg;
        fall_en_next = fall_en_reg;
        irq_en_next  = irq_en_reg;
        w1c          = '0;
        if (write_en) begin
            case (int'(bus.addr))
                GPIO_OUT:     out_next     = (out_reg & ~wr_mask) | wr_bits;
                GPIO_DIR:     dir_next     = (dir_reg & ~wr_mask) | wr_bits;
                GPIO_RISE_EN: rise_en_next = (rise_en_reg & ~wr_mask) | wr_bits;
                GPIO_FALL_EN: fall_en_next = (fall_en_reg & ~wr_mask) | wr_bits;
                GPIO_STAT:    w1c          = wr_bits;
                GPIO_IRQ_EN:  irq_en_next  = bus.wdata[0];
                default:      ;
            endcase
        end
        // New edges are OR-ed in after the clear, so a same-cycle set beats W1C.
        stat_next = (stat_reg & ~w1c) | rise | fall;
    end

    always_comb begin
        rd_mux = '0;
        case (int'(bus.addr))
            GPIO_OUT:     rd_mux = DATA_W'(out_reg);
            GPIO_DIR:     rd_mux = DATA_W'(dir_reg);
            GPIO_IN:      rd_mux = DATA_W'(sync);
            GPIO_RISE_EN: rd_mux = DATA_W'(rise_en_reg);
            GPIO_FALL_EN: rd_mux = DATA_W'(fall_en_reg);
            GPIO_STAT:    rd_mux = DATA_W'(stat_reg);
            GPIO_IRQ_EN:  rd_mux = DATA_W'(irq_en_reg);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_reg      <= '0;
            dir_reg      <= '0;
            rise_en_reg  <= '0;
            fall_en_reg  <= '0;
            stat_reg     <= '0;
            irq_en_reg   <= 1'b0;
            irq_reg      <= 1'b0;
            rdata_reg    <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            out_reg      <= out_next;
            dir_reg      <= dir_next;
            rise_en_reg  <= rise_en_next;
            fall_en_reg  <= fall_en_next;
            stat_reg     <= stat_next;
            irq_en_reg   <= irq_en_next;
            irq_reg      <= irq_en_reg & (|stat_reg);
            rd_valid_reg <= read_en;
            if (read_en) rdata_reg <= rd_mux;
        end
    end

    assign pin_out      = out_reg;
    assign pin_oe       = dir_reg;
    assign irq          = irq_reg;
    assign bus.rdata    = rdata_reg;
    assign bus.rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: scoreboard testbench for gpio_bank with a spec-level model.
module tb_gpio_bank;
    import gpio_pkg::*;

    localparam int N_CH        = 13;
    localparam int DATA_W      = 64;
    localparam int ADDR_W      = 3;
    localparam int SYNC_STAGES = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [N_CH-1:0] pin_in;
    logic [N_CH-1:0] pin_out;
    logic [N_CH-1:0] pin_oe;
    logic            irq;

    gpio_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    gpio_bank #(
        .N_CH        (N_CH),
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pin_oe  (pin_oe),
        .irq     (irq)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int exp_pulses = 0;
    int got_pulses = 0;
    logic [63:0] exp_q[$];

    // Reference model state.
    logic [N_CH-1:0] m_out, m_dir, m_rise, m_fall, m_stat;
    logic            m_irqen, m_irq;
    logic [N_CH-1:0] m_hist[$];   // pin values sampled at past edges, [0] newest
    logic [N_CH-1:0] pins;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_stat = '0;
        m_irqen = 1'b0; m_irq = 1'b0;
        m_hist.delete();
        for (int i = 0; i <= SYNC_STAGES; i++) m_hist.push_back('0);
    endfunction

    function automatic logic [63:0] mask_of(input logic [1:0] s);
        if (s == 2'd0) return 64'hFF;
        if (s == 2'd1) return 64'hFFFF;
        if (s == 2'd2) return 64'hFFFF_FFFF;
        return {64{1'b1}};
    endfunction

    // Applies the bank's rules for one rising edge given the inputs present at it.
    function automatic void model_edge(input logic c, input logic r, input logic w,
                                       input logic [2:0] a, input logic [1:0] s,
                                       input logic [63:0] d, input logic [N_CH-1:0] p);
        logic [N_CH-1:0] mask, wb, syn, prv, rise, fall, w1c, new_stat;
        logic [63:0]     rv;
        logic            we, re, new_irq;
        we   = c & w;
        re   = c & r & ~w;
        mask = N_CH'(mask_of(s));
        wb   = N_CH'(d) & mask;
        syn  = m_hist[SYNC_STAGES-1];
        prv  = m_hist[SYNC_STAGES];
        if (re) begin
            case (a)
                3'd0:    rv = 64'(m_out);
                3'd1:    rv = 64'(m_dir);
                3'd2:    rv = 64'(syn);
                3'd3:    rv = 64'(m_rise);
                3'd4:    rv = 64'(m_fall);
                3'd5:    rv = 64'(m_stat);
                3'd6:    rv = 64'(m_irqen);
                default: rv = 64'd0;
            endcase
            exp_q.push_back(rv);
            exp_pulses++;
        end
        rise     = syn & ~prv & m_rise;
        fall     = ~syn & prv & m_fall;
        w1c      = (we && a == 3'd5) ? wb : '0;
        new_irq  = m_irqen & (m_stat != '0);
        new_stat = (m_stat & ~w1c) | rise | fall;
        if (we) begin
            case (a)
                3'd0: m_out  = (m_out & ~mask) | wb;
                3'd1: m_dir  = (m_dir & ~mask) | wb;
                3'd3: m_rise = (m_rise & ~mask) | wb;
                3'd4: m_fall = (m_fall & ~mask) | wb;
                3'd6: m_irqen = d[0];
                default: ;
            endcase
        end
        m_stat = new_stat;
        m_irq  = new_irq;
        m_hist.push_front(p);
        void'(m_hist.pop_back());
    endfunction

    // One bus cycle: drive at the falling edge, model at the rising edge, check at the next falling edge.
    task automatic cycle(input logic c, input logic r, input logic w, input logic [2:0] a,
                         input logic [1:0] s, input logic [63:0] d);
        bus.cs = c; bus.rd = r; bus.wr = w; bus.addr = a; bus.size = s; bus.wdata = d;
        pin_in = pins;
        if (c && (r || w))
            $display("TXN t=%0t rd=%0b wr=%0b addr=%0d size=%0d wdata=%h pins=%h",
                     $time, r, w, a, s, d, pins);
        @(posedge clock);
        if (reset) model_edge(c, r, w, a, s, d, pins);
        @(negedge clock);
        check("pin_out", 64'(pin_out), 64'(m_out));
        check("pin_oe", 64'(pin_oe), 64'(m_dir));
        check("irq", 64'(irq), 64'(m_irq));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 64'd0);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        cycle(1'b1, 1'b1, 1'b0, a, 2'd3, 64'd0);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [1:0] s, input logic [63:0] d);
        cycle(1'b1, 1'b0, 1'b1, a, s, d);
    endtask

    // Monitor: every rd_valid pops one expected read value.
    initial begin
        forever begin
            @(negedge clock);
            if (bus.rd_valid === 1'b1) begin
                got_pulses++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rd_valid: got rdata %h expected no read", bus.rdata);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    $display("RD  t=%0t rdata=%h", $time, bus.rdata);
                    check("rdata", bus.rdata, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        pins = '0; pin_in = '0;
        bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
        bus.addr = '0; bus.size = '0; bus.wdata = '0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        check("rdata_after_reset", bus.rdata, 64'd0);
        check("rd_valid_after_reset", 64'(bus.rd_valid), 64'd0);
        check("pin_oe_after_reset", 64'(pin_oe), 64'd0);
        check("irq_after_reset", 64'(irq), 64'd0);

        // Reset values read back; back-to-back reads.
        rd_reg(3'd1); rd_reg(3'd0); rd_reg(3'd5);
        idle(1);

        // Sized writes and partial-lane merge.
        wr_reg(3'd0, SZ_D, 64'h1ABC);
        wr_reg(3'd1, SZ_D, 64'h1FFF);
        wr_reg(3'd0, SZ_B, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_reg(3'd0);
        idle(1);

        // Rising-edge capture on pin 2 with interrupt.
        wr_reg(3'd3, SZ_D, 64'h4);
        wr_reg(3'd6, SZ_B, 64'h1);
        pins[2] = 1'b1;
        idle(5);
        rd_reg(3'd5);
        pins[2] = 1'b0;
        idle(5);
        rd_reg(3'd5);
        wr_reg(3'd5, SZ_D, 64'h4);
        idle(2);

        // Falling edge on pin 0 colliding with W1C: the set wins.
        wr_reg(3'd4, SZ_D, 64'h1);
        pins[0] = 1'b1;
        idle(4);
        pins[0] = 1'b0;
        idle(2);
        wr_reg(3'd5, SZ_D, 64'h1);
        rd_reg(3'd5);
        wr_reg(3'd5, SZ_D, 64'h1);
        idle(2);
        rd_reg(3'd2);

        // Write+read together, cs=0 strobes, read-only and unmapped addresses.
        cycle(1'b1, 1'b1, 1'b1, 3'd0, SZ_D, 64'h5);
        cycle(1'b0, 1'b1, 1'b1, 3'd0, SZ_D, 64'h777);
        cycle(1'b0, 1'b1, 1'b0, 3'd1, SZ_D, 64'h0);
        wr_reg(3'd7, SZ_D, 64'hFFFF);
        wr_reg(3'd2, SZ_D, 64'hFFFF);
        rd_reg(3'd7);
        rd_reg(3'd0);
        rd_reg(3'd2);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) pins = pins ^ N_CH'($urandom);
            cycle($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  3'($urandom), 2'($urandom), {$urandom, $urandom});
        end
        idle(2);

        // Reset asserted in the middle of a read.
        wr_reg(3'd0, SZ_D, 64'h1555);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = 3'd0;
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        @(negedge clock);
        bus.cs = 1'b0; bus.rd = 1'b0;
        check("rd_valid_in_reset", 64'(bus.rd_valid), 64'd0);
        check("pin_out_in_reset", 64'(pin_out), 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int a = 0; a < 8; a++) rd_reg(3'(a));
        idle(3);

        check("rd_valid_pulses", 64'(got_pulses), 64'(exp_pulses));
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
